// File: rtl/sn76489_pkg.sv
// sn76489_pkg: register map, byte encoders and FSM states shared by the SN76489 writer
package sn76489_pkg;
  localparam logic [2:0] T1_FREQ = 3'd0, T1_ATTN = 3'd1, T2_FREQ = 3'd2, T2_ATTN = 3'd3;
  localparam logic [2:0] T3_FREQ = 3'd4, T3_ATTN = 3'd5, NOISE_CTL = 3'd6, NOISE_ATTN = 3'd7;
  localparam int LATCH_BIT = 0;
  typedef enum logic [1:0] {IDLE, LATCH, DATA, GAP} state_t;
  function automatic logic is_freq_reg(input logic [2:0] addr);
    return addr == T1_FREQ || addr == T2_FREQ || addr == T3_FREQ;
  endfunction
  function automatic logic [0:7] latch_byte(input logic [2:0] addr, input logic [3:0] lo);
    logic [0:7] b;
    b = {1'b0, addr, lo};
    b[LATCH_BIT] = 1'b1;
    return b;
  endfunction
  function automatic logic [0:7] data_byte(input logic [5:0] hi);
    return {2'b00, hi};
  endfunction
endpackage

// File: rtl/sn76489_cmd_fifo.sv
// sn76489_cmd_fifo: command FIFO with registered ready (no full bypass)
module sn76489_cmd_fifo #(
  parameter int W = 13,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         ready,
  output logic         empty
);
  localparam int DEPTH = 2 ** AW;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nx;
  logic do_push, do_pop;
  assign do_push = push & ready;
  assign do_pop = pop & !empty;
  assign cnt_nx = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign empty = cnt == '0;
  assign rdata = mem[rp];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ready <= 1'b1;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt_nx;
      ready <= cnt_nx != (AW+1)'(DEPTH);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/sn76489_writer.sv
// sn76489_writer: serialises register commands into SN76489 latch/data byte strobes paced by clk_en
module sn76489_writer
  import sn76489_pkg::*;
#(
  parameter int FIFO_AW = 2,
  parameter int GAP_TICKS = 2,
  parameter int SKIP_REDUNDANT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_addr,
  input  logic [9:0] cmd_value,
  input  logic       psg_ready,
  output logic [0:7] d,
  output logic       ce_n,
  output logic       we_n,
  output logic       busy
);
  localparam int CW = $clog2(GAP_TICKS + 2);
  state_t state, state_nx;
  logic [12:0] head;
  logic empty, pop, load_data, strobe_nx, pend, gap_done;
  logic [2:0] hold_addr;
  logic [5:0] hold_hi;
  logic [5:0] shadow [4];
  logic [CW-1:0] gap_cnt;
  logic [0:7] d_nx;
  sn76489_cmd_fifo #(.W(13), .AW(FIFO_AW)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(cmd_valid), .pop(pop),
    .wdata({cmd_addr, cmd_value}), .rdata(head), .ready(cmd_ready), .empty(empty)
  );
  assign gap_done = gap_cnt == CW'(GAP_TICKS);
  assign busy = !empty || state != IDLE;
  assign we_n = ce_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      d <= '0;
      ce_n <= 1'b1;
      hold_addr <= '0;
      hold_hi <= '0;
      pend <= 1'b0;
      gap_cnt <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else begin
      state <= state_nx;
      d <= d_nx;
      ce_n <= !strobe_nx;
      gap_cnt <= state != GAP ? '0 : gap_cnt + CW'(clk_en && !gap_done);
      if (pop) begin
        hold_addr <= head[12:10];
        hold_hi <= head[9:4];
      end
      // shadow mirrors what the PSG holds, so it only changes once the data byte is sampled
      if (state == LATCH && clk_en)
        pend <= is_freq_reg(hold_addr) && (SKIP_REDUNDANT == 0 || hold_hi != shadow[hold_addr[2:1]]);
      if (state == DATA && clk_en) begin
        pend <= 1'b0;
        shadow[hold_addr[2:1]] <= hold_hi;
      end
    end
  always_comb
    state_nx = state == IDLE ? (pop ? LATCH : IDLE) :
               state == GAP  ? (!gap_done ? GAP : !pend ? IDLE : psg_ready ? DATA : GAP) :
               (clk_en ? GAP : state);
  always_comb begin
    pop = state == IDLE && !empty && psg_ready;
    load_data = state == GAP && gap_done && pend && psg_ready;
    strobe_nx = pop || load_data || ((state == LATCH || state == DATA) && !clk_en);
    d_nx = pop ? latch_byte(head[12:10], head[3:0]) : load_data ? data_byte(hold_hi) : d;
  end
endmodule

// File: tb/tb_sn76489_writer.sv
// tb_sn76489_writer: scoreboard bench; expected PSG bytes are queued at issue and popped per sampled strobe
module tb_sn76489_writer;
  logic clk = 0, reset_n = 0, clk_en = 0, cmd_valid = 0, psg_ready = 1, en0 = 0;
  logic [2:0] cmd_addr = 0;
  logic [9:0] cmd_value = 0;
  logic cmd_ready, ce_n, we_n, busy, cmd_valid0, cmd_ready0, ce_n0, we_n0, busy0;
  logic [0:7] d, d0;
  logic [7:0] exp_q[$];
  logic [7:0] got0[$];
  logic [9:0] psg_reg [8];
  logic [2:0] psg_lr;
  logic [7:0] mb, prev_d;
  logic prev_ce = 1, prev_en = 0, seen_low;
  int checks = 0, errors = 0, gap_ticks = 99, en_cnt = 0, n;

  assign cmd_valid0 = cmd_valid & en0;

  sn76489_writer #(.FIFO_AW(2), .GAP_TICKS(2), .SKIP_REDUNDANT(1)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_value(cmd_value), .psg_ready(psg_ready), .d(d), .ce_n(ce_n),
    .we_n(we_n), .busy(busy));
  sn76489_writer #(.FIFO_AW(2), .GAP_TICKS(2), .SKIP_REDUNDANT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_addr(cmd_addr), .cmd_value(cmd_value), .psg_ready(psg_ready), .d(d0), .ce_n(ce_n0),
    .we_n(we_n0), .busy(busy0));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    en_cnt = en_cnt == 15 ? 0 : en_cnt + 1;
    clk_en = en_cnt == 15;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // PSG-side monitor: a byte is taken at each clk edge seeing ce_n=we_n=0 with clk_en=1
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_ce = 1;
      prev_en = 0;
      gap_ticks = 99;
      psg_lr = 0;
      for (int i = 0; i < 8; i++) psg_reg[i] = '0;
    end else begin
      if (!ce_n && prev_ce) chk("gap_ticks_ge2", 32'(gap_ticks >= 2), 1);
      if (!ce_n && !prev_ce) chk("d_stable", 32'(d), 32'(prev_d));
      if (ce_n && !prev_ce) chk("strobe_end_after_clk_en", 32'(prev_en), 1);
      if (!ce_n || !we_n) chk("we_n_tracks_ce_n", 32'(we_n), 32'(ce_n));
      if (!ce_n && !we_n && clk_en) begin
        mb = d;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got %h expected none", mb);
        end else chk("strobe_byte", 32'(mb), 32'(exp_q.pop_front()));
        if (mb[7]) begin
          psg_lr = mb[6:4];
          if (mb[6:4] == 0 || mb[6:4] == 2 || mb[6:4] == 4) psg_reg[psg_lr][3:0] = mb[3:0];
          else psg_reg[psg_lr] = {6'b0, mb[3:0]};
        end else psg_reg[psg_lr][9:4] = mb[5:0];
      end
      gap_ticks = !ce_n ? 0 : gap_ticks + int'(clk_en);
      prev_ce = ce_n;
      prev_en = clk_en;
      prev_d = d;
    end
  end

  always @(negedge clk)
    if (!reset_n) got0.delete();
    else if (!ce_n0 && !we_n0 && clk_en) got0.push_back(d0);

  task automatic push(input logic [2:0] a, input logic [9:0] v);
    int k;
    cmd_valid = 1;
    cmd_addr = a;
    cmd_value = v;
    k = 0;
    while (!cmd_ready && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 400) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    cmd_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_idle"}, {30'b0, busy, ce_n}, 32'd1);
    chk({name, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_ce(input logic lvl, input string name);
    int k;
    k = 0;
    while (ce_n !== lvl && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(name, 32'(ce_n), 32'(lvl));
  endtask

  task automatic do_reset();
    reset_n = 0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d", 32'(d), 0);
    chk("rst_ce_n", 32'(ce_n), 1);
    chk("rst_we_n", 32'(we_n), 1);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 1);
    // frequency write: latch + data
    exp_q.push_back(8'h8E);
    exp_q.push_back(8'h3F);
    push(3'd0, 10'h3FE);
    wait_idle("freq");
    chk("freq_reg0", 32'(psg_reg[0]), 32'h3FE);
    // attenuation: single byte, busy through the gap
    exp_q.push_back(8'h95);
    push(3'd1, 10'h005);
    wait_ce(0, "atten_start");
    wait_ce(1, "atten_end");
    chk("atten_busy_in_gap", 32'(busy), 1);
    wait_idle("atten");
    chk("atten_reg1", 32'(psg_reg[1]), 32'h005);
    // redundant skip vs. SKIP_REDUNDANT=0 instance
    do_reset();
    exp_q.push_back(8'hAA);
    en0 = 1;
    push(3'd2, 10'h00A);
    en0 = 0;
    wait_idle("skip");
    n = 0;
    while (busy0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("noskip_count", 32'(got0.size()), 2);
    if (got0.size() == 2) begin
      chk("noskip_latch", 32'(got0[0]), 32'hAA);
      chk("noskip_data", 32'(got0[1]), 32'h00);
    end
    exp_q.push_back(8'hC5);
    exp_q.push_back(8'h15);
    push(3'd4, 10'h155);
    wait_idle("freq4");
    // back-to-back: fill the FIFO while the PSG is not ready
    psg_ready = 0;
    exp_q.push_back(8'h83);
    exp_q.push_back(8'h12);
    push(3'd0, 10'h123);
    exp_q.push_back(8'hBF);
    push(3'd3, 10'h00F);
    exp_q.push_back(8'hC5);
    push(3'd4, 10'h155);
    exp_q.push_back(8'hE4);
    push(3'd6, 10'h004);
    chk("full_ready_low", 32'(cmd_ready), 0);
    chk("full_busy", 32'(busy), 1);
    chk("full_no_strobe", 32'(ce_n), 1);
    psg_ready = 1;
    exp_q.push_back(8'hAF);
    exp_q.push_back(8'h3F);
    push(3'd2, 10'h3FF);
    wait_idle("b2b");
    chk("b2b_reg0", 32'(psg_reg[0]), 32'h123);
    chk("b2b_reg2", 32'(psg_reg[2]), 32'h3FF);
    chk("b2b_reg3", 32'(psg_reg[3]), 32'h00F);
    chk("b2b_reg4", 32'(psg_reg[4]), 32'h155);
    chk("b2b_reg6", 32'(psg_reg[6]), 32'h004);
    // psg_ready stall with data pending
    exp_q.push_back(8'h87);
    exp_q.push_back(8'h2A);
    push(3'd0, 10'h2A7);
    wait_ce(0, "stall_latch_start");
    wait_ce(1, "stall_latch_end");
    psg_ready = 0;
    seen_low = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (!ce_n) seen_low = 1;
    end
    chk("stall_no_strobe", 32'(seen_low), 0);
    chk("stall_busy", 32'(busy), 1);
    psg_ready = 1;
    n = 0;
    while (ce_n && n < 18) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_release_strobe", 32'(ce_n), 0);
    wait_idle("stall");
    chk("stall_reg0", 32'(psg_reg[0]), 32'h2A7);
    // asynchronous reset in the middle of a strobe
    exp_q.push_back(8'hD7);
    push(3'd5, 10'h007);
    wait_ce(0, "rst_mid_strobe_start");
    #1;
    reset_n = 0;
    exp_q.delete();
    #1;
    chk("rst_mid_ce_n", 32'(ce_n), 1);
    chk("rst_mid_we_n", 32'(we_n), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    @(posedge clk);
    #1;
    chk("rst_mid_ready_after", 32'(cmd_ready), 1);
    chk("rst_mid_busy_after", 32'(busy), 0);
    exp_q.push_back(8'hFF);
    push(3'd7, 10'h00F);
    wait_idle("recover");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sn76489_writer.md
Name: sn76489_writer

Overview:
- Bus-side initiator that drives the SN76489 PSG write port.
- Accepts register-level commands (3-bit register address, 10-bit value) through a valid/ready port and buffers them in a small FIFO.
- Serialises each command into the PSG byte protocol: a latch byte, plus a data byte for tone-frequency registers.
- Paces every byte strobe against the PSG's clk_en, and sits between the sound-CPU mailbox and the PSG instance.

Parameters:
- FIFO_AW, 2, log2 of command FIFO depth (depth 4).
- GAP_TICKS, 2, number of clk_en ticks with ce_n high enforced after every byte strobe.
- SKIP_REDUNDANT, 1, when 1, omit the data byte if a frequency value's upper 6 bits equal the shadow copy.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- clk_en  in  1  PSG clock enable, the same signal that feeds the PSG
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_addr  in  3  PSG register: 0/2/4 tone freq, 1/3/5 tone attn, 6 noise ctl, 7 noise attn
- cmd_value  in  10  register value; only [3:0] is used for non-frequency registers
- psg_ready  in  1  PSG ready; while low, no new byte strobe starts
- d  out  8  bit index [0:7]; d[0] is the MSB
- ce_n  out  1  chip enable, active low
- we_n  out  1  write enable, active low
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (asynchronous, reset_n low):
  - d=8'h00, ce_n=1, we_n=1, cmd_ready=1, busy=0.
  - FIFO is emptied, FSM goes to IDLE, gap counter is cleared.
  - Shadow upper-6-bit registers for regs 0/2/4 are cleared to 0, matching the PSG reset value.
- Reset mid-operation: the strobe releases immediately and any partially sent command is discarded.
- FIFO:
  - Push when cmd_valid & cmd_ready.
  - cmd_ready = !full, registered. No bypass path: a pop while full frees a slot on the next cycle.
  - A push and pop in the same cycle are both honoured.
- Byte encoding, with d[0] as MSB:
  - Latch byte = {1, addr[2:0], value[3:0]}.
  - Data byte = {0, 0, value[9:4]}.
- FSM states: IDLE, LATCH, DATA, GAP.
- IDLE:
  - Advances when the FIFO is non-empty and psg_ready=1.
  - Pops the FIFO head into a holding register, loads the latch byte onto d, drives ce_n=we_n=0, and goes to LATCH.
- LATCH and DATA strobe rule:
  - ce_n=we_n=0 is held until the first clk edge where clk_en=1 (inclusive).
  - The next edge drives ce_n=we_n=1, so the PSG samples each byte exactly once.
  - d stays stable for the whole strobe.
- LATCH exit:
  - Go to GAP.
  - Set the data-pending flag if addr is in {0,2,4}, and also either SKIP_REDUNDANT=0 or value[9:4] differs from the shadow.
- DATA exit:
  - Update the shadow for addr with value[9:4], then go to GAP.
- GAP:
  - Counts GAP_TICKS clk_en pulses with ce_n high.
  - At the end, if data is pending and psg_ready=1: load the data byte, strobe, go to DATA.
  - Otherwise return to IDLE.
  - psg_ready low stalls in GAP (if data pending) or in IDLE.
- Non-frequency registers always produce a single latch byte.
  - The noise ctl write inherently reloads the PSG LFSR, so there is no special case.
- clk_en held low: the strobe is held indefinitely, and there is no timeout.
- Throughput: one command per (1 or 2) × (strobe + GAP_TICKS) clk_en ticks.

Decomposition:
- Shared package sn76489_pkg:
  - register address constants T1_FREQ..NOISE_ATTN (0..7).
  - LATCH_BIT position and the is_freq_reg(addr) function.
  - The state enum {IDLE, LATCH, DATA, GAP}.
- One natural sub-module: sn76489_cmd_fifo, a synchronous FIFO of width 13 (3-bit addr + 10-bit value) with asynchronous active-low reset.

Test Plan:
- Freq write: addr 0, value 10'h3FE, clk_en every 16 clk -> exactly two strobes, d=8'h8E then d=8'h3F. Each strobe ends one cycle after a clk_en pulse. ≥2 clk_en ticks of ce_n high between the strobes.
- Attenuation write: addr 1, value 4'h5 -> single strobe d=8'h95, busy drops after the gap.
- Redundant skip: after reset, addr 2, value 10'h00A -> only d=8'hAA. With SKIP_REDUNDANT=0 the same command gives 8'hAA then 8'h00.
- Back-to-back: 5 commands pushed on consecutive cycles -> cmd_ready low on the 5th (FIFO full). All 5 are emitted in order with no lost or duplicated strobe, checked against a PSG register model.
- psg_ready stall: hold psg_ready=0 during GAP with data pending -> no strobe. Release -> data byte issues within 1 clk_en.
- Reset mid-strobe: deassert reset_n while ce_n=0 -> ce_n=we_n=1 asynchronously, busy=0, cmd_ready=1 after release.
